// File: rtl/cache_types_pkg.sv
// Shared types for the 2-way write-back L1: FSM states, geometry defaults, line/tag types.
package cache_types_pkg;

    localparam int S_INDEX_DEF  = 3;
    localparam int S_OFFSET_DEF = 5;
    localparam int TAG_W        = 32 - S_INDEX_DEF - S_OFFSET_DEF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    typedef logic [255:0]     line_t;
    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/cache_way_array.sv
// One cache way: flop valid/dirty/tag/data arrays, async read, writes on the clock edge.
// Line fill takes priority over word merge; no backpressure, every write lands in one cycle.
module cache_way_array
    import cache_types_pkg::*;
#(
    parameter int S_INDEX  = S_INDEX_DEF,
    parameter int S_OFFSET = S_OFFSET_DEF,
    parameter int TW       = TAG_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [S_INDEX-1:0]    idx_i,
    input  logic                  line_we_i,
    input  line_t                 line_i,
    input  logic [TW-1:0]         tag_i,
    input  logic                  word_we_i,
    input  logic [S_OFFSET-3:0]   word_sel_i,
    input  logic [3:0]            byte_en_i,
    input  logic [31:0]           word_i,
    input  logic                  dirty_clr_i,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [TW-1:0]         tag_o,
    output line_t                 line_o
);

    localparam int NSETS = 1 << S_INDEX;

    logic [NSETS-1:0] valid_q;
    logic [NSETS-1:0] dirty_q;
    logic [TW-1:0]    tag_q  [NSETS];
    line_t            data_q [NSETS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (dirty_clr_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

    // Gated by reset_n so a fill racing a reset never reaches the arrays.
    always_ff @(posedge clk) begin
        if (reset_n && line_we_i) begin
            data_q[idx_i] <= line_i;
            tag_q[idx_i]  <= tag_i;
        end else if (reset_n && word_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en_i[b]) begin
                    data_q[idx_i][32*word_sel_i + 8*b +: 8] <= word_i[8*b +: 8];
                end
            end
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

endmodule

// File: rtl/cache_2way_wb.sv
// 2-way write-back/write-allocate L1: hit resp 2 cycles after request, miss adds writeback+fill.
// CPU holds request until mem_resp; CACHE_STATS_EN adds hit_count/miss_count ports.
module cache_2way_wb
    import cache_types_pkg::*;
#(
    parameter int S_INDEX  = S_INDEX_DEF,
    parameter int S_OFFSET = S_OFFSET_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    input  logic [255:0] pmem_rdata,
    output logic [255:0] pmem_wdata,
    output logic         pmem_read,
    output logic         pmem_write,
    input  logic         pmem_resp
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int TW    = 32 - S_INDEX - S_OFFSET;
    localparam int NSETS = 1 << S_INDEX;

    state_t state_q, state_d;
    logic   victim_q, victim_d;
    logic [NSETS-1:0] lru_q;

    logic [TW-1:0]       req_tag;
    logic [S_INDEX-1:0]  req_idx;
    logic [S_OFFSET-3:0] word_sel;
    logic                unused_addr;

    logic [1:0]    w_valid, w_dirty, hit;
    logic [TW-1:0] w_tag  [2];
    line_t         w_line [2];
    logic [1:0]    line_we, word_we, dirty_clr;
    logic          hit_way, victim_sel, lru_we;

    assign req_tag     = mem_address[31 -: TW];
    assign req_idx     = mem_address[S_OFFSET +: S_INDEX];
    assign word_sel    = mem_address[S_OFFSET-1:2];
    assign unused_addr = ^mem_address[1:0];

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way_array #(
            .S_INDEX  (S_INDEX),
            .S_OFFSET (S_OFFSET),
            .TW       (TW)
        ) u_way (
            .clk         (clk),
            .reset_n     (reset_n),
            .idx_i       (req_idx),
            .line_we_i   (line_we[w]),
            .line_i      (pmem_rdata),
            .tag_i       (req_tag),
            .word_we_i   (word_we[w]),
            .word_sel_i  (word_sel),
            .byte_en_i   (mem_byte_enable),
            .word_i      (mem_wdata),
            .dirty_clr_i (dirty_clr[w]),
            .valid_o     (w_valid[w]),
            .dirty_o     (w_dirty[w]),
            .tag_o       (w_tag[w]),
            .line_o      (w_line[w])
        );
        assign hit[w] = w_valid[w] && (w_tag[w] == req_tag);
    end

    assign hit_way    = hit[1] & ~hit[0];
    // First invalid way wins (way 0 preferred), otherwise the LRU way.
    assign victim_sel = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : lru_q[req_idx]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (lru_we) begin
                lru_q[req_idx] <= ~hit_way;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        line_we      = '0;
        word_we      = '0;
        dirty_clr    = '0;
        lru_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (|hit) begin
                    mem_resp = 1'b1;
                    lru_we   = 1'b1;
                    state_d  = IDLE;
                    if (mem_write) begin
                        word_we[hit_way] = 1'b1;
                    end else begin
                        mem_rdata = w_line[hit_way][32*word_sel +: 32];
                    end
                end else begin
                    victim_d = victim_sel;
                    state_d  = (w_valid[victim_sel] && w_dirty[victim_sel]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {w_tag[victim_q], req_idx, {S_OFFSET{1'b0}}};
                pmem_wdata   = w_line[victim_q];
                if (pmem_resp) begin
                    dirty_clr[victim_q] = 1'b1;
                    state_d             = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, req_idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    line_we[victim_q] = 1'b1;
                    state_d           = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic        retry_q;
    logic        hit_evt, miss_evt;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // The compare right after a fill always hits; it is not a new access.
    assign hit_evt  = (state_q == COMPARE) && (|hit) && !retry_q;
    assign miss_evt = (state_q == COMPARE) && !(|hit);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            retry_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            retry_q <= (state_q == ALLOCATE) && pmem_resp;
            if (hit_evt) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_2way_wb.sv
// Self-checking bench for cache_2way_wb: vector table plus hand sequences, scoreboarded memory.
module tb_cache_2way_wb;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  mem_address;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata, mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata, pmem_wdata;
    logic         pmem_read, pmem_write, pmem_resp;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache_2way_wb dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_rdata      (pmem_rdata),
        .pmem_wdata      (pmem_wdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_resp       (pmem_resp)
`ifdef CACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [255:0] data;
    } mtxn_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          kind;      // 0 hit, 1 clean miss, 2 dirty miss
        logic [31:0] wb_addr;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int lat = 3;
    int busy = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [255:0] mem_model [64];
    logic [255:0] golden    [64];
    mtxn_t        exp_mem_q [$];
    logic [31:0]  exp_rd_q  [$];
    vec_t         vecs      [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pat_line(input int li);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = 32'h5A00_0000 + 32'(li * 256) + 32'(w);
        end
        return l;
    endfunction

    // Memory responder: completes each pmem request after lat cycles and checks it against the scoreboard.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            n_checks++;
            if (pmem_read && pmem_write) begin
                n_errors++;
                $display("FAIL pmem_excl: got read=1 write=1 required at most one");
            end
            if (pmem_read || pmem_write) begin
                busy++;
                if (busy >= lat) begin
                    busy = 0;
                    if (exp_mem_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL pmem_unexpected: got wr=%0d addr=%h required no transaction", pmem_write, pmem_address);
                    end else begin
                        mtxn_t e;
                        e = exp_mem_q.pop_front();
                        chk("pmem_kind", {31'd0, pmem_write}, {31'd0, e.wr});
                        chk("pmem_addr", pmem_address, e.addr);
                        if (e.wr) begin
                            chk_line("pmem_wdata", pmem_wdata, e.data);
                        end
                    end
                    if (pmem_write) begin
                        mem_model[pmem_address[10:5]] = pmem_wdata;
                    end
                    pmem_rdata = mem_model[pmem_address[10:5]];
                    pmem_resp  = 1'b1;
                end
            end else begin
                busy = 0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mem_resp"},  {31'd0, mem_resp}, 32'd0);
        chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
        chk({tag, "_pmem_read"}, {31'd0, pmem_read}, 32'd0);
        chk({tag, "_pmem_write"}, {31'd0, pmem_write}, 32'd0);
        chk({tag, "_pmem_addr"}, pmem_address, 32'd0);
        chk_line({tag, "_pmem_wdata"}, pmem_wdata, 256'd0);
`ifdef CACHE_STATS_EN
        chk({tag, "_hit_count"}, hit_count, 32'd0);
        chk({tag, "_miss_count"}, miss_count, 32'd0);
`endif
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        // Dirty lines held only in the cache are lost by a reset.
        for (int i = 0; i < 64; i++) golden[i] = mem_model[i];
        exp_hits   = 0;
        exp_misses = 0;
        @(posedge clk);
        #1;
        check_idle_outputs("reset");
    endtask

    task automatic cpu_op(input bit wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input int kind, input logic [31:0] wb_addr, input string name);
        int cycles;
        int exp_lat;
        bit got;
        if (kind == 2) exp_mem_q.push_back('{1'b1, wb_addr, golden[wb_addr[10:5]]});
        if (kind >= 1) exp_mem_q.push_back('{1'b0, {a[31:5], 5'b0}, 256'd0});
        if (!wr) exp_rd_q.push_back(exp_rd);
        if (kind == 0) exp_hits++; else exp_misses++;
        exp_lat = (kind == 0) ? 2 : ((kind == 1) ? 3 + lat : 3 + 2 * lat);

        mem_address     = a;
        mem_byte_enable = be;
        mem_wdata       = wd;
        mem_write       = wr;
        mem_read        = !wr;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (mem_resp) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no mem_resp in %0d cycles required one", name, cycles);
            if (!wr) void'(exp_rd_q.pop_front());
        end else begin
            chk({name, "_latency"}, 32'(cycles + 1), 32'(exp_lat));
            if (!wr) chk({name, "_rdata"}, mem_rdata, exp_rd_q.pop_front());
        end
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) golden[a[10:5]][int'(a[4:2]) * 32 + b * 8 +: 8] = wd[b*8 +: 8];
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk({name, "_rdata_idle"}, mem_rdata, 32'd0);
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 64; i++) mem_model[i] = pat_line(i);
        mem_model[2][31:0] = 32'hDEAD_BEEF;

        // Set 2 holds line 0x40; set 3 hosts tags A=0x160, B=0x260, C=0x360.
        vecs[0] = '{1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_005C, 4'h0, 32'h0, 32'h5A00_0207, 0, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0160, 4'h0, 32'h0, 32'h5A00_0B00, 1, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0264, 4'h0, 32'h0, 32'h5A00_1301, 1, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_0168, 4'b1100, 32'hCAFE_0000, 32'h0, 0, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_0270, 4'h0, 32'h0, 32'h5A00_1304, 0, 32'h0};
        vecs[7] = '{1'b0, 32'h0000_036C, 4'h0, 32'h0, 32'h5A00_1B03, 2, 32'h0000_0160};
        vecs[8] = '{1'b0, 32'h0000_0264, 4'h0, 32'h0, 32'h5A00_1301, 0, 32'h0};
        vecs[9] = '{1'b0, 32'h0000_0168, 4'h0, 32'h0, 32'hCAFE_0B02, 1, 32'h0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            cpu_op(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, vecs[i].exp_rd,
                   vecs[i].kind, vecs[i].wb_addr, $sformatf("vec%0d", i));
        end

        // Byte-masked write merge into a freshly filled line.
        mem_model[2] = {8{32'hAAAA_AAAA}};
        do_reset();
        cpu_op(1'b1, 32'h0000_0044, 4'b0011, 32'h1234_5678, 32'h0, 1, 32'h0, "wr44");
        cpu_op(1'b0, 32'h0000_0044, 4'h0, 32'h0, 32'hAAAA_5678, 0, 32'h0, "rd44");

        // Reset while a fill is outstanding abandons it.
        do_reset();
        lat = 50;
        mem_address = 32'h0000_0080;
        mem_read    = 1'b1;
        waited = 0;
        while (!pmem_read && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("abort_pmem_read_seen", {31'd0, pmem_read}, 32'd1);
        chk("abort_pmem_addr", pmem_address, 32'h0000_0080);
        reset_n  = 1'b0;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pmem_read_drop", {31'd0, pmem_read}, 32'd0);
        lat = 3;
        do_reset();
        cpu_op(1'b0, 32'h0000_0080, 4'h0, 32'h0, 32'h5A00_0400, 1, 32'h0, "rd80_miss");
        cpu_op(1'b0, 32'h0000_0080, 4'h0, 32'h0, 32'h5A00_0400, 0, 32'h0, "rd80_hit");
        cpu_op(1'b0, 32'h0000_0084, 4'h0, 32'h0, 32'h5A00_0401, 0, 32'h0, "rd84_hit");
        cpu_op(1'b1, 32'h0000_0088, 4'hF, 32'h0BAD_F00D, 32'h0, 0, 32'h0, "wr88_hit");
        cpu_op(1'b0, 32'h0000_00A0, 4'h0, 32'h0, 32'h5A00_0500, 1, 32'h0, "rdA0_miss");

        repeat (3) @(posedge clk);
        #1;
        chk("mem_q_drained", 32'(exp_mem_q.size()), 32'd0);
`ifdef CACHE_STATS_EN
        chk("hit_count", hit_count, 32'(exp_hits));
        chk("miss_count", miss_count, 32'(exp_misses));
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
